// File: rtl/ttm4_pkg.sv
// ttm4_pkg: shared types for the TTM4 sequencer (opcodes, FSM states, decoded control word).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ttm4_pkg;

  typedef enum logic [3:0] {
    OP_ADD_AI = 4'h0,
    OP_ADD_BI = 4'h1,
    OP_ADD_AB = 4'h2,
    OP_AND_AI = 4'h3,
    OP_OR_AI  = 4'h4,
    OP_XOR_AI = 4'h5,
    OP_AND_AB = 4'h6,
    OP_JZ     = 4'h7,
    OP_MOV_AI = 4'h8,
    OP_MOV_BI = 4'h9,
    OP_MOV_AB = 4'hA,
    OP_MOV_BA = 4'hB,
    OP_IN_A   = 4'hC,
    OP_OUT_A  = 4'hD,
    OP_JNC    = 4'hE,
    OP_JMP    = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2
  } state_e;

  // Destination register; also the register presented on X for ALU ops.
  typedef enum logic {
    DST_A = 1'b0,
    DST_B = 1'b1
  } dst_sel_e;

  typedef enum logic {
    YS_IMM = 1'b0,
    YS_B   = 1'b1
  } ysel_e;

  // Source of the value written into the destination register.
  typedef enum logic [2:0] {
    WS_ALU = 3'd0,
    WS_IMM = 3'd1,
    WS_A   = 3'd2,
    WS_B   = 3'd3,
    WS_IN  = 3'd4
  } wsrc_e;

  typedef enum logic [1:0] {
    JK_NONE   = 2'd0,
    JK_Z      = 2'd1,
    JK_NC     = 2'd2,
    JK_ALWAYS = 2'd3
  } jump_e;

  // ALU unit one-hot, bit order {FA, AND, OR, XOR}.
  localparam logic [3:0] UNIT_FA  = 4'b1000;
  localparam logic [3:0] UNIT_AND = 4'b0100;
  localparam logic [3:0] UNIT_OR  = 4'b0010;
  localparam logic [3:0] UNIT_XOR = 4'b0001;

  typedef struct packed {
    dst_sel_e   dst;
    ysel_e      ysel;
    logic [3:0] unit;
    wsrc_e      wsrc;
    logic       reg_wr;
    logic       out_wr;
    jump_e      jump;
  } ctrl_t;

endpackage

// File: rtl/ttm4_decoder.sv
// ttm4_decoder: maps the IR opcode to the sequencer control word.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   i_opcode  IR[7:4]
//   o_ctrl    decoded control word (all-zero fields mean "no action")
module ttm4_decoder
  import ttm4_pkg::*;
(
  input  logic [3:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (opcode_e'(i_opcode))
      OP_ADD_AI: begin o_ctrl.unit = UNIT_FA;  o_ctrl.reg_wr = 1'b1; end
      OP_ADD_BI: begin o_ctrl.unit = UNIT_FA;  o_ctrl.reg_wr = 1'b1; o_ctrl.dst = DST_B; end
      OP_ADD_AB: begin o_ctrl.unit = UNIT_FA;  o_ctrl.reg_wr = 1'b1; o_ctrl.ysel = YS_B; end
      OP_AND_AI: begin o_ctrl.unit = UNIT_AND; o_ctrl.reg_wr = 1'b1; end
      OP_OR_AI:  begin o_ctrl.unit = UNIT_OR;  o_ctrl.reg_wr = 1'b1; end
      OP_XOR_AI: begin o_ctrl.unit = UNIT_XOR; o_ctrl.reg_wr = 1'b1; end
      OP_AND_AB: begin o_ctrl.unit = UNIT_AND; o_ctrl.reg_wr = 1'b1; o_ctrl.ysel = YS_B; end
      OP_JZ:     o_ctrl.jump = JK_Z;
      OP_MOV_AI: begin o_ctrl.wsrc = WS_IMM; o_ctrl.reg_wr = 1'b1; end
      OP_MOV_BI: begin o_ctrl.wsrc = WS_IMM; o_ctrl.reg_wr = 1'b1; o_ctrl.dst = DST_B; end
      OP_MOV_AB: begin o_ctrl.wsrc = WS_B;   o_ctrl.reg_wr = 1'b1; end
      OP_MOV_BA: begin o_ctrl.wsrc = WS_A;   o_ctrl.reg_wr = 1'b1; o_ctrl.dst = DST_B; end
      OP_IN_A:   begin o_ctrl.wsrc = WS_IN;  o_ctrl.reg_wr = 1'b1; end
      OP_OUT_A:  o_ctrl.out_wr = 1'b1;
      OP_JNC:    o_ctrl.jump = JK_NC;
      OP_JMP:    o_ctrl.jump = JK_ALWAYS;
      default:   o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ttm4_sequencer.sv
// ttm4_sequencer: TTM4 fetch/decode/execute sequencer feeding the ALU and writing back its result.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE); all updates on EXECUTE's closing edge.
// Backpressure: none; with TTM4_SEQ_SINGLE_STEP_EN defined, FETCH holds until STEP is sampled high.
//
// Ports:
//   CLK, RST          clock; asynchronous active-high reset
//   ROM_ADDR/ROM_DATA program ROM address (= PC) and instruction (valid one cycle later)
//   X, Y              ALU operands, zero unless an ALU op is executing
//   nFA_EN..nXOR_EN   active-low ALU unit enables, low only in EXECUTE of an ALU op
//   STOREDATA         ALU result, sampled only on ALU-op EXECUTE edges
//   Z_FLAG, C_FLAG    ALU flag register outputs, used by JZ/JNC
//   IN_PORT/OUT_PORT  input port (sampled by IN A), registered output port (loaded by OUT A)
//   STEP              single-step advance, only when TTM4_SEQ_SINGLE_STEP_EN is defined
module ttm4_sequencer
  import ttm4_pkg::*;
#(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [3:0] ROM_ADDR,
  input  logic [7:0] ROM_DATA,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       nFA_EN,
  output logic       nAND_EN,
  output logic       nOR_EN,
  output logic       nXOR_EN,
  input  logic [3:0] STOREDATA,
  input  logic       Z_FLAG,
  input  logic       C_FLAG,
  input  logic [3:0] IN_PORT,
  output logic [3:0] OUT_PORT
`ifdef TTM4_SEQ_SINGLE_STEP_EN
  ,
  input  logic       STEP
`endif
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_pc;
  logic [7:0] r_ir;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_out;

  ctrl_t      w_ctrl;
  logic       w_exec;
  logic       w_alu_op;
  logic       w_step_ok;
  logic       w_take;
  logic [3:0] w_imm;
  logic [3:0] w_dst_val;
  logic [3:0] w_y_val;
  logic [3:0] w_wdata;
  logic [3:0] w_pc_nxt;

`ifdef TTM4_SEQ_SINGLE_STEP_EN
  assign w_step_ok = STEP;
`else
  assign w_step_ok = 1'b1;
`endif

  ttm4_decoder u_dec (
    .i_opcode (r_ir[7:4]),
    .o_ctrl   (w_ctrl)
  );

  assign w_imm = r_ir[3:0];

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; w_exec marks the cycle whose closing edge commits the instruction
  always_comb begin
    w_state_nxt = r_state;
    w_exec      = 1'b0;
    case (r_state)
      ST_FETCH:   if (w_step_ok) w_state_nxt = ST_DECODE;
      ST_DECODE:  w_state_nxt = ST_EXECUTE;
      ST_EXECUTE: begin
        w_state_nxt = ST_FETCH;
        w_exec      = 1'b1;
      end
      default:    w_state_nxt = ST_FETCH;
    endcase
  end

  // ALU-facing outputs are qualified by EXECUTE so a reset mid-instruction
  // releases the enables and operands immediately.
  assign w_alu_op  = w_exec && (w_ctrl.unit != 4'b0000);
  assign w_dst_val = (w_ctrl.dst == DST_B) ? r_b : r_a;
  assign w_y_val   = (w_ctrl.ysel == YS_B) ? r_b : w_imm;

  assign X        = w_alu_op ? w_dst_val : 4'h0;
  assign Y        = w_alu_op ? w_y_val   : 4'h0;
  assign nFA_EN   = ~(w_exec & w_ctrl.unit[3]);
  assign nAND_EN  = ~(w_exec & w_ctrl.unit[2]);
  assign nOR_EN   = ~(w_exec & w_ctrl.unit[1]);
  assign nXOR_EN  = ~(w_exec & w_ctrl.unit[0]);
  assign ROM_ADDR = r_pc;
  assign OUT_PORT = r_out;

  // STOREDATA is only selected for ALU ops; MOV/IN/OUT move data internally.
  always_comb begin
    w_wdata = STOREDATA;
    case (w_ctrl.wsrc)
      WS_ALU:  w_wdata = STOREDATA;
      WS_IMM:  w_wdata = w_imm;
      WS_A:    w_wdata = r_a;
      WS_B:    w_wdata = r_b;
      WS_IN:   w_wdata = IN_PORT;
      default: w_wdata = STOREDATA;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    case (w_ctrl.jump)
      JK_NONE:   w_take = 1'b0;
      JK_Z:      w_take = Z_FLAG;
      JK_NC:     w_take = ~C_FLAG;
      JK_ALWAYS: w_take = 1'b1;
      default:   w_take = 1'b0;
    endcase
  end

  // 4-bit add wraps F -> 0 naturally.
  assign w_pc_nxt = w_take ? w_imm : (r_pc + 4'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc  <= RESET_PC;
      r_ir  <= 8'h00;
      r_a   <= 4'h0;
      r_b   <= 4'h0;
      r_out <= 4'h0;
    end else begin
      // ROM data for the address presented in FETCH is valid during DECODE.
      if (r_state == ST_DECODE) r_ir <= ROM_DATA;
      if (w_exec) begin
        r_pc <= w_pc_nxt;
        if (w_ctrl.reg_wr && (w_ctrl.dst == DST_A)) r_a <= w_wdata;
        if (w_ctrl.reg_wr && (w_ctrl.dst == DST_B)) r_b <= w_wdata;
        if (w_ctrl.out_wr) r_out <= r_a;
      end
    end
  end

endmodule

// File: tb/tb_ttm4_sequencer.sv
`timescale 1ns/1ps
module tb_ttm4_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] ROM_ADDR;
  logic [7:0] ROM_DATA = 8'h00;
  logic [3:0] X, Y;
  logic       nFA_EN, nAND_EN, nOR_EN, nXOR_EN;
  logic [3:0] STOREDATA;
  logic       Z_FLAG, C_FLAG;
  logic [3:0] IN_PORT = 4'hA;
  logic [3:0] OUT_PORT;
`ifdef TTM4_SEQ_SINGLE_STEP_EN
  logic       STEP = 1'b1;
`endif

  ttm4_sequencer #(.RESET_PC(4'h0)) dut (
    .CLK(CLK), .RST(RST), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .X(X), .Y(Y), .nFA_EN(nFA_EN), .nAND_EN(nAND_EN), .nOR_EN(nOR_EN), .nXOR_EN(nXOR_EN),
    .STOREDATA(STOREDATA), .Z_FLAG(Z_FLAG), .C_FLAG(C_FLAG),
    .IN_PORT(IN_PORT), .OUT_PORT(OUT_PORT)
`ifdef TTM4_SEQ_SINGLE_STEP_EN
    , .STEP(STEP)
`endif
  );

  always #5 CLK = ~CLK;

  // Registered program ROM
  logic [7:0] rom [16];
  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

  // ALU model: combinational units, flag register loaded on ADD edges only
  logic [4:0] sum5;
  assign sum5 = {1'b0, X} + {1'b0, Y};
  always_comb begin
    STOREDATA = 4'h0;
    if (!nFA_EN)       STOREDATA = sum5[3:0];
    else if (!nAND_EN) STOREDATA = X & Y;
    else if (!nOR_EN)  STOREDATA = X | Y;
    else if (!nXOR_EN) STOREDATA = X ^ Y;
  end
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      Z_FLAG <= 1'b0;
      C_FLAG <= 1'b0;
    end else if (!nFA_EN) begin
      Z_FLAG <= (sum5[3:0] == 4'h0);
      C_FLAG <= sum5[4];
    end
  end

  // Expected per-instruction response; en bit order {nFA,nAND,nOR,nXOR}
  typedef struct {
    logic [3:0] pc, x, y, en, next_pc, out;
    bit         chk_xy;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   pend = 1'b0;
  bit   mon_en = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   phase = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_alu(input logic [3:0] pc, x, y, en, npc, out);
    exp_t e;
    e.pc = pc; e.x = x; e.y = y; e.en = en; e.next_pc = npc; e.out = out; e.chk_xy = 1'b1;
    q.push_back(e);
  endtask

  task automatic exp_ctl(input logic [3:0] pc, npc, out);
    exp_t e;
    e.pc = pc; e.x = 4'h0; e.y = 4'h0; e.en = 4'hF; e.next_pc = npc; e.out = out; e.chk_xy = 1'b0;
    q.push_back(e);
  endtask

  // Phase of the 3-cycle instruction as seen from outside: 0 FETCH, 1 DECODE, 2 EXECUTE
  always @(posedge CLK or posedge RST) begin
    if (RST) phase <= 0;
    else     phase <= (phase == 2) ? 0 : phase + 1;
  end

  // Monitor: pops an expectation at each EXECUTE, checks commit results at the next FETCH
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        pend = 1'b0;
      end else if (mon_en) begin
        if (phase != 2) begin
          chk("idle_en", {nFA_EN, nAND_EN, nOR_EN, nXOR_EN}, 4'hF);
          chk("idle_x", X, 4'h0);
          chk("idle_y", Y, 4'h0);
        end
        if (phase == 0 && pend) begin
          chk("next_pc", ROM_ADDR, cur.next_pc);
          chk("out_port", OUT_PORT, cur.out);
          pend = 1'b0;
        end
        if (phase == 2 && q.size() != 0) begin
          cur = q.pop_front();
          chk("exec_pc", ROM_ADDR, cur.pc);
          chk("exec_en", {nFA_EN, nAND_EN, nOR_EN, nXOR_EN}, cur.en);
          if (cur.chk_xy) begin
            chk("exec_x", X, cur.x);
            chk("exec_y", Y, cur.y);
          end
          pend = 1'b1;
        end
      end
    end
  end

  task automatic load_rom(input logic [7:0] img [16]);
    for (int i = 0; i < 16; i++) rom[i] = img[i];
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int k;
    k = 0;
    while ((q.size() != 0 || pend) && k < bound) begin
      @(negedge CLK);
      k++;
    end
    n_chk++;
    if (q.size() != 0 || pend) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d expectations left, expected 0", name, q.size());
      q.delete();
      pend = 1'b0;
    end
  endtask

  logic [7:0] img [16];

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_en", {nFA_EN, nAND_EN, nOR_EN, nXOR_EN}, 4'hF);
    chk("rst_x", X, 4'h0);
    chk("rst_y", Y, 4'h0);
    chk("rst_pc", ROM_ADDR, 4'h0);
    chk("rst_out", OUT_PORT, 4'h0);

    // P1: MOV A,3; ADD A,2; OUT A; IN A; OUT A
    img = '{8'h83, 8'h02, 8'hD0, 8'hC0, 8'hD0, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_rom(img);
    exp_ctl(4'h0, 4'h1, 4'h0);
    exp_alu(4'h1, 4'h3, 4'h2, 4'b0111, 4'h2, 4'h0);
    exp_ctl(4'h2, 4'h3, 4'h5);
    exp_ctl(4'h3, 4'h4, 4'h5);
    exp_ctl(4'h4, 4'h5, 4'hA);
    do_reset();
    wait_done("p1", 60);

    // P2: carry/zero jumps, JMP from PC=F
    img = '{8'h8F, 8'hD0, 8'h01, 8'hE0, 8'hD0, 8'h01, 8'hE9, 8'hD0,
            8'h00, 8'hD0, 8'h0F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'hF7};
    load_rom(img);
    exp_ctl(4'h0, 4'h1, 4'h0);
    exp_ctl(4'h1, 4'h2, 4'hF);
    exp_alu(4'h2, 4'hF, 4'h1, 4'b0111, 4'h3, 4'hF);
    exp_ctl(4'h3, 4'h4, 4'hF);                        // JNC 0, C=1: not taken
    exp_ctl(4'h4, 4'h5, 4'h0);
    exp_alu(4'h5, 4'h0, 4'h1, 4'b0111, 4'h6, 4'h0);
    exp_ctl(4'h6, 4'h9, 4'h0);                        // JNC 9, C=0: taken
    exp_ctl(4'h9, 4'hA, 4'h1);
    exp_alu(4'hA, 4'h1, 4'hF, 4'b0111, 4'hB, 4'h1);
    exp_ctl(4'hB, 4'hF, 4'h1);                        // JZ F, Z=1: taken
    exp_ctl(4'hF, 4'h7, 4'h1);                        // JMP 7 at PC=F
    exp_ctl(4'h7, 4'h8, 4'h0);
    do_reset();
    wait_done("p2", 120);

    // P3: logic ops, B-operand forms, JZ not taken, ADD B, wrap F -> 0
    img = '{8'h9C, 8'hA0, 8'h55, 8'hD0, 8'h96, 8'hA0, 8'hD0, 8'h3C,
            8'h43, 8'h60, 8'h20, 8'h7F, 8'hB0, 8'h1F, 8'hA0, 8'hD0};
    load_rom(img);
    exp_ctl(4'h0, 4'h1, 4'h0);
    exp_ctl(4'h1, 4'h2, 4'h0);
    exp_alu(4'h2, 4'hC, 4'h5, 4'b1110, 4'h3, 4'h0);   // XOR: C^5 = 9
    exp_ctl(4'h3, 4'h4, 4'h9);
    exp_ctl(4'h4, 4'h5, 4'h9);
    exp_ctl(4'h5, 4'h6, 4'h9);
    exp_ctl(4'h6, 4'h7, 4'h6);
    exp_alu(4'h7, 4'h6, 4'hC, 4'b1011, 4'h8, 4'h6);   // AND: 6&C = 4
    exp_alu(4'h8, 4'h4, 4'h3, 4'b1101, 4'h9, 4'h6);   // OR: 4|3 = 7
    exp_alu(4'h9, 4'h7, 4'h6, 4'b1011, 4'hA, 4'h6);   // AND A,B: 7&6 = 6
    exp_alu(4'hA, 4'h6, 4'h6, 4'b0111, 4'hB, 4'h6);   // ADD A,B: C, Z=0
    exp_ctl(4'hB, 4'hC, 4'h6);                        // JZ not taken
    exp_ctl(4'hC, 4'hD, 4'h6);                        // B = C
    exp_alu(4'hD, 4'hC, 4'hF, 4'b0111, 4'hE, 4'h6);   // ADD B,F: B = B
    exp_ctl(4'hE, 4'hF, 4'h6);                        // A = B
    exp_ctl(4'hF, 4'h0, 4'hB);                        // OUT at F, wraps to 0
    do_reset();
    wait_done("p3", 120);

    // Reset during EXECUTE of ADD aborts the writeback
    img = '{8'h83, 8'h02, 8'hD0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load_rom(img);
    mon_en = 1'b0;
    do_reset();
    repeat (5) @(negedge CLK);
    #1;
    chk("abort_pre_fa", {3'b000, nFA_EN}, 4'h0);
    chk("abort_pre_x", X, 4'h3);
    RST = 1'b1;
    #1;
    chk("abort_en", {nFA_EN, nAND_EN, nOR_EN, nXOR_EN}, 4'hF);
    chk("abort_x", X, 4'h0);
    chk("abort_y", Y, 4'h0);
    chk("abort_pc", ROM_ADDR, 4'h0);
    chk("abort_out", OUT_PORT, 4'h0);
    rom[0] = 8'h20;                                   // ADD A,B exposes A on X
    rom[1] = 8'hD0;
    exp_alu(4'h0, 4'h0, 4'h0, 4'b0111, 4'h1, 4'h0);
    exp_ctl(4'h1, 4'h2, 4'h0);
    @(negedge CLK);
    mon_en = 1'b1;
    do_reset();
    wait_done("abort", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
